// File: rtl/branch_ctrl_r0_pkg.sv
// Shared pipeline constants for the ID-stage branch controller: FSM encoding
// and the stall-cycle counts a branch may need before its operands are ready.
package branch_ctrl_r0_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    HAZ_WAIT = 1'b1
  } br_state_t;

  localparam logic [1:0] STALL_NONE = 2'd0;
  localparam logic [1:0] STALL_ONE  = 2'd1;
  localparam logic [1:0] STALL_TWO  = 2'd2;

  function automatic logic [1:0] max_stall(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_ctrl_r0_hazard.sv
// Combinational producer matching for an ID-stage branch: how many cycles the
// comparator must wait, and which operands can take the MEM ALU result now.
module branch_hazard_detect_r0
  import branch_ctrl_r0_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic [1:0]            stall_n,
  output logic                  fwd_a,
  output logic                  fwd_b
);

  logic ex_hit;
  logic mem_hit_a;
  logic mem_hit_b;
  logic [1:0] n_ex;
  logic [1:0] n_mem;

  // r0 is hardwired zero, so a producer writing it never creates a dependence
  assign ex_hit    = (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
  assign mem_hit_a = (mem_rd != '0) && (mem_rd == id_rs);
  assign mem_hit_b = (mem_rd != '0) && (mem_rd == id_rt);

  always_comb begin
    n_ex  = STALL_NONE;
    n_mem = STALL_NONE;
    if (ex_hit && ex_mem_read)       n_ex = STALL_TWO;
    else if (ex_hit && ex_reg_write) n_ex = STALL_ONE;
    if ((mem_hit_a || mem_hit_b) && mem_mem_read) n_mem = STALL_ONE;
    stall_n = max_stall(n_ex, n_mem);
  end

  assign fwd_a = mem_reg_write && !mem_mem_read && mem_hit_a;
  assign fwd_b = mem_reg_write && !mem_mem_read && mem_hit_b;

endmodule

// File: rtl/branch_ctrl_r0.sv
// ID-stage branch resolution: stalls until the comparator operands are
// available, then redirects the PC and flushes IF/ID on a taken branch.
module branch_ctrl_r0
  import branch_ctrl_r0_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_beq,
  input  logic                  id_bne,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [BIT_WIDTH-1:0]  id_pc_plus4,
  input  logic [15:0]           id_imm,
  input  logic                  equal,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  stall,
  output logic                  fwd_a,
  output logic                  fwd_b,
  output logic                  pc_sel,
  output logic [BIT_WIDTH-1:0]  branch_target,
  output logic                  if_flush
);

  localparam int EXT_W = BIT_WIDTH - 18;

  br_state_t  state;
  logic [1:0] cnt;
  logic [1:0] stall_n;
  logic       branch;
  logic       taken;
  logic       resolve;

  branch_hazard_detect_r0 #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_rd        (mem_rd),
    .stall_n       (stall_n),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  assign branch = id_valid && (id_beq || id_bne);
  // BEQ wins when both decode bits are set
  assign taken  = id_beq ? equal : !equal;

  assign branch_target = id_pc_plus4 + {{EXT_W{id_imm[15]}}, id_imm, 2'b00};

  // Reset suppresses stall and resolution so a pending branch is aborted cleanly
  always_comb begin
    stall   = 1'b0;
    resolve = 1'b0;
    if (!rst && branch) begin
      case (state)
        IDLE:     if (stall_n != STALL_NONE) stall = 1'b1; else resolve = 1'b1;
        HAZ_WAIT: if (cnt != 2'd0) stall = 1'b1; else resolve = 1'b1;
        default:  stall = 1'b0;
      endcase
    end
  end

  assign pc_sel   = resolve && taken;
  assign if_flush = resolve && taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (branch && (stall_n != STALL_NONE)) begin
            state <= HAZ_WAIT;
            cnt   <= stall_n - 2'd1;
          end
        end
        HAZ_WAIT: begin
          if (!branch) begin
            state <= IDLE;
            cnt   <= 2'd0;
          end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl_r0.sv
// Directed bench for branch_ctrl_r0: a cycle-level model of branch timing runs
// beside hand-computed literal checks of the characteristic scenarios.
module tb_branch_ctrl_r0;

  localparam int BW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_beq, id_bne, equal;
  logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic [BW-1:0] id_pc_plus4;
  logic [15:0]   id_imm;
  logic          ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read;
  logic          stall, fwd_a, fwd_b, pc_sel, if_flush;
  logic [BW-1:0] branch_target;

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] exp_q[$];

  // model state: a branch is waiting for m_need stall cycles, m_done spent so far
  bit m_busy = 0;
  int m_need = 0;
  int m_done = 0;

  branch_ctrl_r0 #(.BIT_WIDTH(BW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_beq(id_beq), .id_bne(id_bne),
    .id_rs(id_rs), .id_rt(id_rt), .id_pc_plus4(id_pc_plus4), .id_imm(id_imm),
    .equal(equal), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_rd(mem_rd), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .pc_sel(pc_sel), .branch_target(branch_target), .if_flush(if_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_beq = 0; id_bne = 0; equal = 0;
    id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
    id_pc_plus4 = '0; id_imm = '0;
    ex_reg_write = 0; ex_mem_read = 0; mem_reg_write = 0; mem_mem_read = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic set_branch(input bit beq, input bit bne, input int rs, input int rt,
                            input logic [BW-1:0] pc, input logic [15:0] imm, input bit eq);
    id_valid = 1; id_beq = beq; id_bne = bne;
    id_rs = AW'(rs); id_rt = AW'(rt); id_pc_plus4 = pc; id_imm = imm; equal = eq;
  endtask

  // Stall cycles needed: the largest requirement among the producers in flight
  function automatic int need_cycles();
    int  n = 0;
    bit  ex_m  = (ex_rd != 0) && (ex_rd == id_rs || ex_rd == id_rt);
    bit  mem_m = (mem_rd != 0) && (mem_rd == id_rs || mem_rd == id_rt);
    if (ex_m && ex_mem_read) n = 2;
    if (ex_m && ex_reg_write && !ex_mem_read && n < 1) n = 1;
    if (mem_m && mem_mem_read && n < 1) n = 1;
    return n;
  endfunction

  always @(negedge clk) begin
    bit br, tk, exp_stall, exp_res, exp_fa, exp_fb;
    logic [BW-1:0] exp_tgt;
    int n;
    br = id_valid && (id_beq || id_bne);
    tk = id_beq ? equal : !equal;
    exp_stall = 0;
    exp_res   = 0;
    if (rst) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (br) begin
        n = need_cycles();
        if (n == 0) exp_res = 1;
        else begin
          exp_stall = 1; m_busy = 1; m_need = n; m_done = 1;
        end
      end
    end else if (!br) begin
      m_busy = 0;
    end else if (m_done < m_need) begin
      exp_stall = 1; m_done++;
    end else begin
      exp_res = 1; m_busy = 0;
    end
    exp_fa  = mem_reg_write && !mem_mem_read && mem_rd != 0 && mem_rd == id_rs;
    exp_fb  = mem_reg_write && !mem_mem_read && mem_rd != 0 && mem_rd == id_rt;
    exp_tgt = id_pc_plus4 + BW'(int'($signed(id_imm)) * 4);
    if (!rst) chk("model_stall", BW'(stall), BW'(exp_stall));
    chk("model_pc_sel", BW'(pc_sel), BW'(exp_res && tk));
    chk("model_if_flush", BW'(if_flush), BW'(exp_res && tk));
    chk("model_fwd_a", BW'(fwd_a), BW'(exp_fa));
    chk("model_fwd_b", BW'(fwd_b), BW'(exp_fb));
    chk("model_target", branch_target, exp_tgt);
    if (exp_res && tk) exp_q.push_back(exp_tgt);
    if (pc_sel) begin
      if (exp_q.size() == 0) chk("sb_unexpected_redirect", BW'(pc_sel), '0);
      else chk("sb_redirect_target", branch_target, exp_q.pop_front());
    end
  end

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) next_cycle();
    rst = 0;
    settle();
    chk("rst_stall", BW'(stall), 0);
    chk("rst_pc_sel", BW'(pc_sel), 0);
    chk("rst_if_flush", BW'(if_flush), 0);
    chk("rst_fwd_a", BW'(fwd_a), 0);
    chk("rst_fwd_b", BW'(fwd_b), 0);

    // BEQ taken, no hazard: resolves in the same cycle
    next_cycle(); clear_inputs();
    set_branch(1, 0, 1, 2, 32'h100, 16'h0004, 1);
    settle();
    chk("beq_taken_pc_sel", BW'(pc_sel), 1);
    chk("beq_taken_flush", BW'(if_flush), 1);
    chk("beq_taken_target", branch_target, 32'h110);
    chk("beq_taken_stall", BW'(stall), 0);

    // BNE with equal operands: not taken, negative offset target
    next_cycle(); clear_inputs();
    set_branch(0, 1, 1, 2, 32'h100, 16'hFFFF, 1);
    settle();
    chk("bne_nt_pc_sel", BW'(pc_sel), 0);
    chk("bne_nt_flush", BW'(if_flush), 0);
    chk("bne_nt_target", branch_target, 32'hFC);

    // EX load into rs: two stall cycles, resolve on the third
    next_cycle(); clear_inputs();
    set_branch(1, 0, 3, 4, 32'h400, 16'h0010, 0);
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 5'd3;
    settle();
    chk("ld2_c1_stall", BW'(stall), 1);
    chk("ld2_c1_pc_sel", BW'(pc_sel), 0);
    next_cycle(); clear_inputs();
    set_branch(1, 0, 3, 4, 32'h400, 16'h0010, 0);
    mem_reg_write = 1; mem_mem_read = 1; mem_rd = 5'd3;
    settle();
    chk("ld2_c2_stall", BW'(stall), 1);
    next_cycle(); clear_inputs();
    set_branch(1, 0, 3, 4, 32'h400, 16'h0010, 1);
    settle();
    chk("ld2_c3_stall", BW'(stall), 0);
    chk("ld2_c3_pc_sel", BW'(pc_sel), 1);
    chk("ld2_c3_target", branch_target, 32'h440);

    // EX ALU into rt: one stall, then MEM forwarding on rt and resolve
    next_cycle(); clear_inputs();
    set_branch(1, 0, 6, 5, 32'h200, 16'hFFFE, 0);
    ex_reg_write = 1; ex_rd = 5'd5;
    settle();
    chk("alu1_c1_stall", BW'(stall), 1);
    next_cycle(); clear_inputs();
    set_branch(1, 0, 6, 5, 32'h200, 16'hFFFE, 1);
    mem_reg_write = 1; mem_rd = 5'd5;
    settle();
    chk("alu1_c2_fwd_b", BW'(fwd_b), 1);
    chk("alu1_c2_fwd_a", BW'(fwd_a), 0);
    chk("alu1_c2_stall", BW'(stall), 0);
    chk("alu1_c2_pc_sel", BW'(pc_sel), 1);
    chk("alu1_c2_target", branch_target, 32'h1F8);

    // r0 never matches
    next_cycle(); clear_inputs();
    set_branch(1, 0, 0, 7, 32'h300, 16'h0001, 1);
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 5'd0;
    settle();
    chk("r0_stall", BW'(stall), 0);
    chk("r0_pc_sel", BW'(pc_sel), 1);

    // id_valid drops while waiting: abort without resolution
    next_cycle(); clear_inputs();
    set_branch(1, 0, 3, 4, 32'h500, 16'h0002, 1);
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 5'd3;
    settle();
    chk("abort_c1_stall", BW'(stall), 1);
    next_cycle(); clear_inputs();
    equal = 1;
    settle();
    chk("abort_c2_stall", BW'(stall), 0);
    chk("abort_c2_pc_sel", BW'(pc_sel), 0);

    // Reset while waiting with one stall left: no redirect, FSM back to IDLE
    next_cycle(); clear_inputs();
    set_branch(1, 0, 3, 4, 32'h600, 16'h0003, 1);
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 5'd3;
    settle();
    chk("rstw_c1_stall", BW'(stall), 1);
    next_cycle(); clear_inputs();
    set_branch(1, 0, 3, 4, 32'h600, 16'h0003, 1);
    rst = 1;
    settle();
    chk("rstw_c2_pc_sel", BW'(pc_sel), 0);
    chk("rstw_c2_flush", BW'(if_flush), 0);
    next_cycle(); clear_inputs();
    rst = 0;
    settle();
    chk("rstw_c3_stall", BW'(stall), 0);
    chk("rstw_c3_pc_sel", BW'(pc_sel), 0);
    chk("rstw_c3_flush", BW'(if_flush), 0);
    next_cycle(); clear_inputs();
    set_branch(1, 0, 1, 2, 32'h700, 16'h0000, 1);
    settle();
    chk("rstw_c4_pc_sel", BW'(pc_sel), 1);
    chk("rstw_c4_target", branch_target, 32'h700);

    // Non-branch with a load dependence never stalls; fwd still reported
    next_cycle(); clear_inputs();
    id_valid = 1; id_rs = 5'd3; id_rt = 5'd9; equal = 1;
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 5'd3;
    mem_reg_write = 1; mem_rd = 5'd3;
    settle();
    chk("nonbr_stall", BW'(stall), 0);
    chk("nonbr_pc_sel", BW'(pc_sel), 0);
    chk("nonbr_fwd_a", BW'(fwd_a), 1);

    // BEQ and BNE both set: BEQ semantics
    next_cycle(); clear_inputs();
    set_branch(1, 1, 1, 2, 32'h800, 16'h0001, 1);
    settle();
    chk("both_eq_pc_sel", BW'(pc_sel), 1);
    next_cycle(); clear_inputs();
    set_branch(1, 1, 1, 2, 32'h800, 16'h0001, 0);
    settle();
    chk("both_ne_pc_sel", BW'(pc_sel), 0);

    // MEM load into rs: one stall; a MEM load is never forwarded
    next_cycle(); clear_inputs();
    set_branch(0, 1, 8, 9, 32'h900, 16'h0004, 0);
    mem_reg_write = 1; mem_mem_read = 1; mem_rd = 5'd8;
    settle();
    chk("memld_c1_stall", BW'(stall), 1);
    chk("memld_c1_fwd_a", BW'(fwd_a), 0);
    next_cycle(); clear_inputs();
    set_branch(0, 1, 8, 9, 32'h900, 16'h0004, 0);
    settle();
    chk("memld_c2_pc_sel", BW'(pc_sel), 1);
    chk("memld_c2_target", branch_target, 32'h910);

    // EX ALU plus MEM load both matching: max is one stall
    next_cycle(); clear_inputs();
    set_branch(1, 0, 10, 11, 32'hA00, 16'h8000, 1);
    ex_reg_write = 1; ex_rd = 5'd10; mem_reg_write = 1; mem_mem_read = 1; mem_rd = 5'd11;
    settle();
    chk("mix_c1_stall", BW'(stall), 1);
    next_cycle(); clear_inputs();
    set_branch(1, 0, 10, 11, 32'hA00, 16'h8000, 1);
    settle();
    chk("mix_c2_stall", BW'(stall), 0);
    chk("mix_c2_target", branch_target, 32'hFFFE_0A00);

    next_cycle(); clear_inputs();
    repeat (2) next_cycle();
    chk("sb_queue_drained", BW'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_ctrl_r0.md
BRANCH_CTRL_R0 -- requirements
Module: branch_ctrl_r0

Interface
REQ-001 Parameter BIT_WIDTH, default 32: datapath/PC width.
REQ-002 Parameter REG_ADDR_W, default 5: register address width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 id_valid  in  1  ID holds a valid instruction.
REQ-007 id_beq / id_bne  in  1 each  ID instruction is BEQ / BNE.
REQ-008 id_rs / id_rt  in  REG_ADDR_W each  branch source registers.
REQ-009 id_pc_plus4  in  BIT_WIDTH  PC+4 of the ID instruction.
REQ-010 id_imm  in  16  raw branch offset field.
REQ-011 equal  in  1  operand-equality flag from the ID comparator.
REQ-012 ex_reg_write, ex_mem_read  in  1 each; ex_rd  in  REG_ADDR_W  EX-stage destination info.
REQ-013 mem_reg_write, mem_mem_read  in  1 each; mem_rd  in  REG_ADDR_W  MEM-stage destination info.
REQ-014 stall  out  1  hold PC and IF/ID, insert bubble into EX.
REQ-015 fwd_a / fwd_b  out  1 each  comparator operand select: 1 = MEM ALU result, 0 = register file.
REQ-016 pc_sel  out  1  1 = load branch_target into PC.
REQ-017 branch_target  out  BIT_WIDTH  computed branch destination.
REQ-018 if_flush  out  1  squash IF/ID contents.

Function
REQ-019 Branch = id_valid & (id_beq | id_bne). If both are asserted, the instruction SHALL be treated as BEQ.
REQ-020 Dependence: a producer matches when its rd is nonzero and equals id_rs or id_rt. Register 0 SHALL never match.
REQ-021 Stall count n SHALL be the maximum of the following, or 0 if none apply:
- 2 if EX matches with ex_mem_read=1;
- 1 if EX matches with ex_reg_write=1 and ex_mem_read=0;
- 1 if MEM matches with mem_mem_read=1.
REQ-022 The FSM SHALL have two states, IDLE and HAZ_WAIT, plus a 2-bit down-counter cnt.
REQ-023 IDLE with branch and n>0:
- stall=1 combinationally in that cycle;
- next state HAZ_WAIT with cnt=n-1;
- no resolution in that cycle.
REQ-024 HAZ_WAIT:
- if cnt!=0: stall=1, cnt decrements;
- if cnt==0: stall=0, resolve, go to IDLE.
- Total stall cycles SHALL equal n.
REQ-025 IDLE with branch and n==0 SHALL resolve in the same cycle (zero added latency).
REQ-026 Resolve cycle only:
- taken = (beq & equal) | (bne & ~equal), with BEQ precedence per REQ-019;
- pc_sel = taken; if_flush = taken.
- Outside resolve cycles, pc_sel=0 and if_flush=0.
REQ-027 branch_target SHALL equal id_pc_plus4 + (sign-extended id_imm shifted left 2), modulo 2^BIT_WIDTH. It is driven every cycle; its value matters only while pc_sel=1.
REQ-028 fwd_a SHALL be 1 when mem_reg_write & ~mem_mem_read and mem_rd matches id_rs (nonzero). fwd_b is identical using id_rt.
REQ-029 If id_valid deasserts while in HAZ_WAIT, the FSM SHALL return to IDLE next cycle with stall=0 and no resolution.
REQ-030 Non-branch instructions SHALL never cause stall, pc_sel or if_flush.

Reset
REQ-031 While rst=1 at a clock edge:
- state goes to IDLE and cnt to 0;
- stall, pc_sel, if_flush, fwd_a, fwd_b SHALL be 0 in the following cycle.
REQ-032 Reset asserted during HAZ_WAIT SHALL abort the pending branch with no resolution.

Structure
REQ-033 FSM state encoding and the stall-count constants (0/1/2) SHALL live in the shared pipeline constants package/header.
REQ-034 Hazard matching and n computation SHALL be one combinational sub-module, branch_hazard_detect_r0. The FSM, target adder and output logic stay in branch_ctrl_r0.

Verification
REQ-035 BEQ, no hazard, equal=1, pc_plus4=0x100, imm=0x0004 -> same cycle pc_sel=1, if_flush=1, target=0x110, stall=0.
REQ-036 BNE, equal=1, imm=0xFFFF, pc_plus4=0x100 -> pc_sel=0, target=0xFC, no flush.
REQ-037 BEQ rs=3, EX load rd=3 -> stall=1 for exactly 2 cycles, then resolve on the 3rd cycle.
REQ-038 BEQ rt=5, EX ALU rd=5 -> 1 stall cycle; next cycle with MEM ALU rd=5 -> fwd_b=1 and resolve.
REQ-039 BEQ rs=0, EX load rd=0 -> no stall, immediate resolve.
REQ-040 Branch in HAZ_WAIT with cnt=1, rst=1 for one cycle -> IDLE next cycle, all outputs 0, no pc_sel pulse.
